// File: rtl/lcv_mul_wide_seq_if.sv
// Operand/product handshake bundle for the sequenced wide multiplier.
// master drives operands and accepts products; slave is the multiplier.
interface lcv_mul_wide_seq_if #(
  parameter int WIDTH = 32
);
  logic                 inp_valid;
  logic                 inp_ready;
  logic [WIDTH-1:0]     inp_a;
  logic [WIDTH-1:0]     inp_b;
  logic                 inp_signed;
  logic                 outp_valid;
  logic                 outp_ready;
  logic [2*WIDTH-1:0]   outp_data;

  modport master (
    output inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    input  inp_ready, outp_valid, outp_data
  );

  modport slave (
    input  inp_valid, inp_a, inp_b, inp_signed, outp_ready,
    output inp_ready, outp_valid, outp_data
  );
endinterface

// File: rtl/lcv_mul_wide_seq.sv
// WIDTH x WIDTH -> 2*WIDTH multiply sequenced over one registered HALF x HALF MAC.
// Latency 6 cycles accept->valid; one op in flight; accepts only when idle, holds result until taken.
module lcv_mul_wide_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  lcv_mul_wide_seq_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_P0    = 3'd1;
  localparam logic [2:0] S_P1    = 3'd2;
  localparam logic [2:0] S_P2    = 3'd3;
  localparam logic [2:0] S_P3    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_FIX   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [WIDTH-1:0]   ONE_W  = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W = 1;

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     prod_q, prod_d;
  logic [2*WIDTH-1:0]   data_q, data_d;

  logic [HALF-1:0]      mac_x;
  logic [HALF-1:0]      mac_y;
  logic [2*WIDTH-1:0]   prod_ext;

  assign prod_ext = {{WIDTH{1'b0}}, prod_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    data_d  = data_q;
    mac_x   = '0;
    mac_y   = '0;

    // Each Pk issues a partial product and folds in the one issued the cycle before.
    case (state_q)
      S_IDLE: begin
        if (bus.inp_valid) begin
          a_d     = (bus.inp_signed && bus.inp_a[WIDTH-1]) ? (~bus.inp_a + ONE_W) : bus.inp_a;
          b_d     = (bus.inp_signed && bus.inp_b[WIDTH-1]) ? (~bus.inp_b + ONE_W) : bus.inp_b;
          neg_d   = bus.inp_signed & (bus.inp_a[WIDTH-1] ^ bus.inp_b[WIDTH-1]);
          acc_d   = '0;
          state_d = S_P0;
        end
      end
      S_P0: begin
        mac_x   = a_q[HALF-1:0];
        mac_y   = b_q[HALF-1:0];
        state_d = S_P1;
      end
      S_P1: begin
        mac_x   = a_q[HALF-1:0];
        mac_y   = b_q[WIDTH-1:HALF];
        acc_d   = acc_q + prod_ext;
        state_d = S_P2;
      end
      S_P2: begin
        mac_x   = a_q[WIDTH-1:HALF];
        mac_y   = b_q[HALF-1:0];
        acc_d   = acc_q + (prod_ext << HALF);
        state_d = S_P3;
      end
      S_P3: begin
        mac_x   = a_q[WIDTH-1:HALF];
        mac_y   = b_q[WIDTH-1:HALF];
        acc_d   = acc_q + (prod_ext << HALF);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d   = acc_q + (prod_ext << WIDTH);
        state_d = S_FIX;
      end
      S_FIX: begin
        acc_d   = neg_q ? (~acc_q + ONE_2W) : acc_q;
        data_d  = acc_d;
        state_d = S_DONE;
      end
      default: begin
        if (bus.outp_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase

    prod_d = {{HALF{1'b0}}, mac_x} * {{HALF{1'b0}}, mac_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      prod_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      data_q  <= data_d;
    end
  end

  assign bus.inp_ready  = (state_q == S_IDLE);
  assign bus.outp_valid = (state_q == S_DONE);
  assign bus.outp_data  = data_q;
endmodule

// File: tb/tb_lcv_mul_wide_seq.sv
// Directed bench for lcv_mul_wide_seq: products, latency, stall, reset abort, back-to-back pacing.
module tb_lcv_mul_wide_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lcv_mul_wide_seq_if #(.WIDTH(W)) bus ();

  lcv_mul_wide_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drives one op from idle and takes the product; lat=20 means no valid appeared.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.inp_a      = a;
    bus.inp_b      = b;
    bus.inp_signed = s;
    bus.inp_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inp_valid = 1'b0;
    lat = 0;
    while (bus.outp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = bus.outp_data;
    if (lat < 20) begin
      bus.outp_ready = 1'b1;
      @(negedge clk);
      bus.outp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.inp_ready !== 1'b1) begin
      errors++; $display("FAIL reset_inp_ready: got %b want 1", bus.inp_ready);
    end
    checks++;
    if (bus.outp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outp_valid: got %b want 0", bus.outp_valid);
    end
    checks++;
    if (bus.outp_data !== 64'h0) begin
      errors++; $display("FAIL reset_outp_data: got %h want 0", bus.outp_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_max();
    logic [63:0] r; int lat;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, lat);
    checks++;
    if (r !== 64'hFFFFFFFE_00000001) begin
      errors++; $display("FAIL umax_data: got %h want fffffffe00000001", r);
    end
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL umax_latency: got %0d want 6", lat);
    end
  endtask

  task automatic test_signed();
    logic [63:0] r; int lat;
    do_op(32'hFFFFFFFD, 32'h00000005, 1'b1, r, lat);
    checks++;
    if (r !== 64'hFFFFFFFF_FFFFFFF1 || lat !== 6) begin
      errors++; $display("FAIL signed_m3x5: got %h lat %0d want fffffffffffffff1 lat 6", r, lat);
    end
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
    checks++;
    if (r !== 64'h00000000_00000001 || lat !== 6) begin
      errors++; $display("FAIL signed_m1xm1: got %h lat %0d want 0000000000000001 lat 6", r, lat);
    end
  endtask

  task automatic test_most_negative();
    logic [63:0] r; int lat;
    do_op(32'h80000000, 32'h80000000, 1'b1, r, lat);
    checks++;
    if (r !== 64'h40000000_00000000 || lat !== 6) begin
      errors++; $display("FAIL smin_sq: got %h lat %0d want 4000000000000000 lat 6", r, lat);
    end
    do_op(32'h80000000, 32'h80000000, 1'b0, r, lat);
    checks++;
    if (r !== 64'h40000000_00000000 || lat !== 6) begin
      errors++; $display("FAIL umin_sq: got %h lat %0d want 4000000000000000 lat 6", r, lat);
    end
    do_op(32'h80000000, 32'h00000001, 1'b1, r, lat);
    checks++;
    if (r !== 64'hFFFFFFFF_80000000 || lat !== 6) begin
      errors++; $display("FAIL smin_x1: got %h lat %0d want ffffffff80000000 lat 6", r, lat);
    end
  endtask

  task automatic test_stall();
    logic [63:0] held; logic [63:0] r; int lat;
    @(negedge clk);
    bus.inp_a = 32'hFFFFFFFD; bus.inp_b = 32'h00000005; bus.inp_signed = 1'b1;
    bus.inp_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inp_valid = 1'b0;
    lat = 0;
    while (bus.outp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    held = bus.outp_data;
    checks++;
    if (held !== 64'hFFFFFFFF_FFFFFFF1 || lat !== 6) begin
      errors++; $display("FAIL stall_first: got %h lat %0d want fffffffffffffff1 lat 6", held, lat);
    end
    for (int i = 0; i < 10; i++) begin
      bus.inp_valid = i[0];
      bus.inp_a     = 32'h12340000 + i;
      bus.inp_b     = 32'h00000003;
      @(negedge clk);
      checks++;
      if (bus.outp_valid !== 1'b1 || bus.outp_data !== held || bus.inp_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid %b data %h ready %b want 1 %h 0",
                 i, bus.outp_valid, bus.outp_data, bus.inp_ready, held);
      end
    end
    bus.inp_valid  = 1'b0;
    bus.outp_ready = 1'b1;
    @(negedge clk);
    bus.outp_ready = 1'b0;
    checks++;
    if (bus.outp_valid !== 1'b0 || bus.inp_ready !== 1'b1 || bus.outp_data !== held) begin
      errors++;
      $display("FAIL stall_release: got valid %b ready %b data %h want 0 1 %h",
               bus.outp_valid, bus.inp_ready, bus.outp_data, held);
    end
    do_op(32'h00000003, 32'h00000004, 1'b0, r, lat);
    checks++;
    if (r !== 64'h000000000000000C || lat !== 6) begin
      errors++; $display("FAIL stall_next: got %h lat %0d want 000000000000000c lat 6", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; int lat; int seen;
    @(negedge clk);
    bus.inp_a = 32'h00001234; bus.inp_b = 32'h00005678; bus.inp_signed = 1'b0;
    bus.inp_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.inp_ready !== 1'b1 || bus.outp_valid !== 1'b0 || bus.outp_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ready %b valid %b data %h want 1 0 0",
               bus.inp_ready, bus.outp_valid, bus.outp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.outp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_no_valid: got %0d valid cycles want 0", seen);
    end
    do_op(32'h00010000, 32'h00010000, 1'b0, r, lat);
    checks++;
    if (r !== 64'h00000001_00000000 || lat !== 6) begin
      errors++; $display("FAIL rst_mid_next: got %h lat %0d want 0000000100000000 lat 6", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [8] = '{32'h00000002, 32'hFFFFFFFE, 32'h00010001, 32'h7FFFFFFF,
                            32'h80000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] tb [8] = '{32'h00000003, 32'h00000007, 32'h00010001, 32'h7FFFFFFF,
                            32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000010};
    logic        ts [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] te [8] = '{64'h00000000_00000006, 64'hFFFFFFFF_FFFFFFF2,
                            64'h00000001_00020001, 64'h3FFFFFFF_00000001,
                            64'h00000000_80000000, 64'h00000001_00000000,
                            64'h00000000_00000000, 64'h0000000F_FFFFFFF0};
    int idx = 0;
    int ridx = 0;
    int last_acc = -1;
    @(negedge clk);
    bus.inp_a = ta[0]; bus.inp_b = tb[0]; bus.inp_signed = ts[0];
    bus.inp_valid  = 1'b1;
    bus.outp_ready = 1'b1;
    for (int c = 0; c < 200 && ridx < 8; c++) begin
      if (bus.outp_valid === 1'b1) begin
        checks++;
        if (bus.outp_data !== te[ridx]) begin
          errors++; $display("FAIL b2b_data[%0d]: got %h want %h", ridx, bus.outp_data, te[ridx]);
        end
        ridx++;
      end
      if (bus.inp_ready === 1'b1 && idx < 8) begin
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != 8) begin
            errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 8", idx, c - last_acc);
          end
        end
        last_acc = c;
        idx++;
      end
      @(negedge clk);
      if (idx < 8) begin
        bus.inp_a = ta[idx]; bus.inp_b = tb[idx]; bus.inp_signed = ts[idx];
      end else begin
        bus.inp_valid = 1'b0;
      end
    end
    checks++;
    if (ridx != 8) begin
      errors++; $display("FAIL b2b_count: got %0d results want 8", ridx);
    end
    bus.inp_valid  = 1'b0;
    bus.outp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.inp_valid  = 1'b0;
    bus.inp_a      = '0;
    bus.inp_b      = '0;
    bus.inp_signed = 1'b0;
    bus.outp_ready = 1'b0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_most_negative();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
